// File: rtl/fp_align_rshift.sv
// Mantissa alignment right-shifter with guard/round/sticky, valid/ready on both sides.
// Define ALIGN_BARREL_EN for a single-cycle barrel shift; the default build iterates STEP bits per cycle.
module fp_align_rshift #(
    parameter int WIDTH = 24,
    parameter int SHW   = 8,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [2:0]       out_grs
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE outputs hold until out_ready.
    localparam int WW = WIDTH + 2;
    localparam logic [SHW-1:0] SAT_MAX  = SHW'(WW);
    localparam logic [SHW-1:0] STEP_MAX = SHW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic           accept;
    logic [SHW-1:0] sat;
    logic [WW-1:0]  load_word;

    // Returns {w >> k, OR of the bits shifted out}; k == WW drops every bit.
    function automatic logic [WW:0] shift_right(input logic [WW-1:0] w, input logic [SHW-1:0] k);
        logic [WW-1:0] lost_mask;
        lost_mask = ~({WW{1'b1}} << k);
        return {w >> k, |(w & lost_mask)};
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign sat       = (in_shamt > SAT_MAX) ? SAT_MAX : in_shamt;
    assign load_word = {in_mant, 2'b00};

`ifndef ALIGN_BARREL_EN
    logic [WW-1:0]  work;
    logic           sticky;
    logic [SHW-1:0] rem;
    logic [SHW-1:0] step_k;
    logic [WW:0]    step_res;
    logic           step_sticky;
    logic           last_step;

    assign step_k      = (rem < STEP_MAX) ? rem : STEP_MAX;
    assign step_res    = shift_right(work, step_k);
    assign step_sticky = sticky | step_res[0];
    assign last_step   = (rem == step_k);
`else
    logic [WW:0] bar_res;

    assign bar_res = shift_right(load_word, sat);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALIGN_BARREL_EN
                    state_next = DONE;
`else
                    state_next = (sat == '0) ? DONE : SHIFT;
`endif
                end
            end
`ifndef ALIGN_BARREL_EN
            SHIFT: if (last_step) state_next = DONE;
`endif
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Results are written only on the transition into DONE and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mant <= '0;
            out_grs  <= '0;
`ifndef ALIGN_BARREL_EN
            work     <= '0;
            sticky   <= 1'b0;
            rem      <= '0;
`endif
        end else begin
`ifdef ALIGN_BARREL_EN
            if (accept) begin
                out_mant <= bar_res[WW:3];
                out_grs  <= bar_res[2:0];
            end
`else
            if (accept) begin
                work   <= load_word;
                sticky <= 1'b0;
                rem    <= sat;
                if (sat == '0) begin
                    out_mant <= in_mant;
                    out_grs  <= 3'b000;
                end
            end else if (state == SHIFT) begin
                work   <= step_res[WW:1];
                sticky <= step_sticky;
                rem    <= rem - step_k;
                if (last_step) begin
                    out_mant <= step_res[WW:3];
                    out_grs  <= {step_res[2:1], step_sticky};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_fp_align_rshift.sv
// Self-checking bench for fp_align_rshift: directed cases, random ops against a reference model,
// output back-pressure and mid-operation reset.
module tb_fp_align_rshift;

    localparam int WIDTH = 24;
    localparam int SHW   = 8;
    localparam int STEP  = 4;
`ifdef ALIGN_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant = '0;
    logic [SHW-1:0]   in_shamt = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_mant;
    logic [2:0]       out_grs;

    int tests_run = 0;
    int tests_failed = 0;

    fp_align_rshift #(.WIDTH(WIDTH), .SHW(SHW), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_grs   (out_grs)
    );

    always #5 clk = ~clk;

    // Reference: treat {mant,00} as an integer, divide by 2^sat, keep every lost bit for sticky.
    function automatic void ref_model(input logic [WIDTH-1:0] m, input logic [SHW-1:0] sh,
                                      output logic [WIDTH-1:0] om, output logic [2:0] grs,
                                      output int lat);
        int sat;
        logic [63:0] v;
        logic [63:0] sv;
        logic [63:0] lost;
        sat  = (int'(sh) > WIDTH + 2) ? WIDTH + 2 : int'(sh);
        v    = 64'(m) * 64'd4;
        sv   = v >> sat;
        lost = v % (64'd1 << sat);
        om   = sv[WIDTH+1:2];
        grs  = {sv[1], sv[0], lost != 64'd0};
        lat  = BARREL ? 1 : 1 + (sat + STEP - 1) / STEP;
    endfunction

    task automatic send(input logic [WIDTH-1:0] m, input logic [SHW-1:0] sh);
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = m;
        in_shamt = sh;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, out_mant, out_grs} !== {1'b1, 1'b0, 24'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset: rdy=%b vld=%b mant=%h grs=%b, want 1 0 000000 000",
                     in_ready, out_valid, out_mant, out_grs);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] dm [5] = '{24'hC00001, 24'h800001, 24'hFFFFFF, 24'h800000, 24'h000005};
        logic [SHW-1:0]   ds [5] = '{8'd0, 8'd1, 8'd10, 8'd25, 8'd200};
        logic [WIDTH-1:0] wm [5] = '{24'hC00001, 24'h400000, 24'h003FFF, 24'h000000, 24'h000000};
        logic [2:0]       wg [5] = '{3'b000, 3'b100, 3'b111, 3'b010, 3'b001};
        int               wl [5] = '{1, 2, 4, 8, 8};
        int lat;
        bit busy_ok;
        for (int i = 0; i < 5; i++) begin
            send(dm[i], ds[i]);
            busy_ok = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (in_ready !== 1'b0) busy_ok = 1'b0;
            end while (!out_valid && lat < 40);
            tests_run++;
            if (out_mant !== wm[i] || out_grs !== wg[i]) begin
                tests_failed++;
                $display("FAIL directed%0d value: mant=%h grs=%b, want %h %b",
                         i, out_mant, out_grs, wm[i], wg[i]);
            end
            tests_run++;
            if (lat !== (BARREL ? 1 : wl[i])) begin
                tests_failed++;
                $display("FAIL directed%0d latency: got %0d, want %0d",
                         i, lat, BARREL ? 1 : wl[i]);
            end
            tests_run++;
            if (!busy_ok) begin
                tests_failed++;
                $display("FAIL directed%0d in_ready: high while busy, want 0", i);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] em;
        logic [2:0]       eg;
        int el;
        int lat;
        for (int i = 0; i < 150; i++) begin
            m  = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? SHW'($urandom) : SHW'($urandom_range(0, 30));
            ref_model(m, sh, em, eg, el);
            send(m, sh);
            wait_valid(lat);
            tests_run++;
            if (out_mant !== em || out_grs !== eg || lat !== el) begin
                tests_failed++;
                $display("FAIL random m=%h sh=%0d: mant=%h grs=%b lat=%0d, want %h %b %0d",
                         m, sh, out_mant, out_grs, lat, em, eg, el);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out();
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] em;
        logic [2:0]       eg;
        int el;
        int lat;
        bit stable;
        ref_model(24'h9A5C33, 8'd7, em, eg, el);
        send(24'h9A5C33, 8'd7);
        wait_valid(lat);
        in_valid = 1'b1;
        in_mant  = 24'h123457;
        in_shamt = 8'd3;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_mant !== em || out_grs !== eg || in_ready !== 1'b0)
                stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL hold: vld=%b mant=%h grs=%b rdy=%b, want 1 %h %b 0",
                     out_valid, out_mant, out_grs, in_ready, em, eg);
        end
        release_out();
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_mant !== em) begin
            tests_failed++;
            $display("FAIL hold_idle: rdy=%b mant=%h, want 1 %h", in_ready, out_mant, em);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        ref_model(24'h123457, 8'd3, em, eg, el);
        wait_valid(lat);
        tests_run++;
        if (out_mant !== em || out_grs !== eg || lat !== el) begin
            tests_failed++;
            $display("FAIL back_to_back: mant=%h grs=%b lat=%0d, want %h %b %0d",
                     out_mant, out_grs, lat, em, eg, el);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        bit seen;
        send(24'hABCDEF, 8'd20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_mant, out_grs} !== {1'b1, 1'b0, 24'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_mid: rdy=%b vld=%b mant=%h grs=%b, want 1 0 000000 000",
                     in_ready, out_valid, out_mant, out_grs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out_mant !== 24'h0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL reset_abandon: result appeared after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_directed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
